// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequential IEEE-754 single-precision multiplier (shift-add significands).
// Ports:
//   clk, rst (sync, active-low), en (clock enable)
//   start, a, b        : request and operands, captured when accepted in IDLE
//   busy, done         : handshake; done is a one-enabled-cycle pulse
//   result, overflow, underflow, invalid : product and mutually exclusive flags
// BITS_PER_CYCLE must divide 24 (1, 2, 3, 4, 6, 8, 12, 24).
module fp_mul_seq #(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned MUL_CYCLES     = 24 / BITS_PER_CYCLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  localparam int unsigned CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_NORM, S_ROUND} state_t;

  state_t             r_state, w_next;
  logic [31:0]        r_a, r_b;
  logic               r_first;
  logic [CW-1:0]      r_cnt;
  logic [47:0]        r_mcand, r_acc;
  logic [23:0]        r_mplr;
  logic signed [9:0]  r_exp;
  logic               r_sign, r_spec, r_spec_inv;
  logic [31:0]        r_spec_res;

  // Operand unpack and special-case classification from the captured operands
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_ma, w_mb;
  logic        w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic        w_spec, w_spec_inv;
  logic [31:0] w_spec_res;

  assign w_ea     = r_a[30:23];
  assign w_eb     = r_b[30:23];
  assign w_ma     = r_a[22:0];
  assign w_mb     = r_b[22:0];
  assign w_sign   = r_a[31] ^ r_b[31];
  assign w_a_zero = (w_ea == 8'd0);
  assign w_b_zero = (w_eb == 8'd0);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_ma == 23'd0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_mb == 23'd0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_ma != 23'd0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_mb != 23'd0);

  always_comb begin
    w_spec     = 1'b1;
    w_spec_inv = 1'b0;
    w_spec_res = 32'h7FC0_0000;
    if (w_a_nan || w_b_nan) begin
      w_spec_res = 32'h7FC0_0000;
    end else if ((w_a_zero && w_b_inf) || (w_a_inf && w_b_zero)) begin
      w_spec_inv = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_res = {w_sign, 8'hFF, 23'd0};
    end else if (w_a_zero || w_b_zero) begin
      w_spec_res = {w_sign, 31'd0};
    end else begin
      w_spec = 1'b0;
    end
  end

  // Partial product for the multiplier bits consumed this cycle
  logic [47:0] w_pp;
  always_comb begin
    w_pp = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      if (r_mplr[i]) w_pp = w_pp + (r_mcand << i);
    end
  end

  // Round-to-nearest-even on the normalised product (leading one at bit 46)
  logic               w_g, w_st, w_up;
  logic [24:0]        w_m25;
  logic signed [9:0]  w_exp_r;
  logic [22:0]        w_frac;
  logic [31:0]        w_res;
  logic               w_ovf, w_unf;

  assign w_g     = r_acc[22];
  assign w_st    = |r_acc[21:0];
  assign w_up    = w_g & (w_st | r_acc[23]);
  assign w_m25   = {2'b01, r_acc[45:23]} + 25'(w_up);
  assign w_exp_r = r_exp + $signed({9'd0, w_m25[24]});
  assign w_frac  = w_m25[24] ? w_m25[23:1] : w_m25[22:0];

  always_comb begin
    w_res = {r_sign, w_exp_r[7:0], w_frac};
    w_ovf = 1'b0;
    w_unf = 1'b0;
    if (r_spec) begin
      w_res = r_spec_res;
    end else if (w_exp_r >= 10'sd255) begin
      w_res = {r_sign, 8'hFF, 23'd0};
      w_ovf = 1'b1;
    end else if (w_exp_r <= 10'sd0) begin
      w_res = {r_sign, 31'd0};
      w_unf = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst)    r_state <= S_IDLE;
    else if (en) r_state <= w_next;
  end

  // FSM next state; the first MUL cycle is an unpack/setup cycle before accumulation
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_MUL;
      S_MUL:   if (!r_first && (r_cnt == '0)) w_next = S_NORM;
      S_NORM:  w_next = S_ROUND;
      S_ROUND: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_first    <= 1'b0;
      r_cnt      <= '0;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_acc      <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_inv <= 1'b0;
      r_spec_res <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      invalid    <= 1'b0;
    end else if (en) begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a       <= a;
            r_b       <= b;
            r_first   <= 1'b1;
            busy      <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
          end
        end
        S_MUL: begin
          if (r_first) begin
            r_first    <= 1'b0;
            r_mcand    <= {24'd0, 1'b1, w_ma};
            r_mplr     <= {1'b1, w_mb};
            r_acc      <= '0;
            r_cnt      <= CW'(MUL_CYCLES - 1);
            r_exp      <= 10'(w_ea) + 10'(w_eb) - 10'd127;
            r_sign     <= w_sign;
            r_spec     <= w_spec;
            r_spec_inv <= w_spec_inv;
            r_spec_res <= w_spec_res;
          end else begin
            r_acc   <= r_acc + w_pp;
            r_mcand <= r_mcand << BITS_PER_CYCLE;
            r_mplr  <= r_mplr >> BITS_PER_CYCLE;
            r_cnt   <= r_cnt - CW'(1);
          end
        end
        S_NORM: begin
          // Bit shifted out folds into bit 0 so the sticky is preserved
          if (r_acc[47]) begin
            r_acc <= {1'b0, r_acc[47:2], r_acc[1] | r_acc[0]};
            r_exp <= r_exp + 10'sd1;
          end
        end
        S_ROUND: begin
          result    <= w_res;
          overflow  <= w_ovf;
          underflow <= w_unf;
          invalid   <= r_spec & r_spec_inv;
          done      <= 1'b1;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: directed and randomized checks of fp_mul_seq against an arithmetic model.
module tb_fp_mul_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, overflow, underflow, invalid;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  fp_mul_seq dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact integer product, then round-to-nearest-even by remainder comparison
  function automatic void ref_mul(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] fl);
    int ex, ey, e, sh;
    logic s, xz, yz, xi, yi, xn, yn;
    longint unsigned p, q, rem, half;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    fl = 3'b000;
    if (xn || yn) r = 32'h7FC0_0000;
    else if ((xz && yi) || (xi && yz)) begin r = 32'h7FC0_0000; fl = 3'b001; end
    else if (xi || yi) r = {s, 8'hFF, 23'd0};
    else if (xz || yz) r = {s, 31'd0};
    else begin
      p  = longint'({1'b1, x[22:0]}) * longint'({1'b1, y[22:0]});
      e  = ex + ey - 127;
      sh = 23;
      if (p >= (64'd1 << 47)) begin sh = 24; e = e + 1; end
      q    = p >> sh;
      rem  = p - (q << sh);
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
      if (q >= (64'd1 << 24)) begin q = q >> 1; e = e + 1; end
      if (e >= 255) begin r = {s, 8'hFF, 23'd0}; fl = 3'b100; end
      else if (e <= 0) begin r = {s, 31'd0}; fl = 3'b010; end
      else r = {s, 8'(e), q[22:0]};
    end
  endfunction

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
  endtask

  // One full operation with expected latency, result and flags {ovf,unf,inv}
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [2:0] ef);
    int n;
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, " latency"}, 32'(n), 32'd27);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, {29'd0, overflow, underflow, invalid}, {29'd0, ef});
    tick();
    check({tag, " done_drop"}, {30'd0, done, busy}, 32'd0);
  endtask

  task automatic run_model(input string tag, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] er;
    logic [2:0]  ef;
    ref_mul(x, y, er, ef);
    run_op(tag, x, y, er, ef);
  endtask

  initial begin
    int n, pulses;
    logic [31:0] x, y;

    // Reset state
    tick(); tick();
    check("reset outs", {26'd0, busy, done, overflow, underflow, invalid, 1'b0}, 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b1;
    tick();

    // Directed vectors
    run_op("1.5x2",    32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);
    run_op("-1.5x2",   32'hBFC0_0000, 32'h4000_0000, 32'hC040_0000, 3'b000);
    run_op("rnd",      32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 3'b000);
    run_op("tie_even", 32'h3F80_0001, 32'h3FC0_0000, 32'h3FC0_0002, 3'b000);
    run_op("0xinf",    32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 3'b001);
    run_op("nan",      32'h7FC0_0000, 32'h3F80_0000, 32'h7FC0_0000, 3'b000);
    run_op("-infx2",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 3'b000);
    run_op("ovf",      32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 3'b100);
    run_op("unf",      32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 3'b010);
    run_op("denorm",   32'h0040_0000, 32'h3F80_0000, 32'h0000_0000, 3'b000);

    // Start while busy is ignored: one done, original result
    a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    a = 32'h4000_0000; b = 32'h4000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    check("busy_start latency", 32'(n + 5), 32'd27);
    check("busy_start result", result, 32'h4040_0000);
    pulses = 0;
    repeat (40) begin tick(); if (done) pulses++; end
    check("busy_start pulses", 32'(pulses), 32'd0);

    // en low for 10 cycles mid-MUL delays done by exactly 10
    a = 32'h3F80_0001; b = 32'h3FC0_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    en = 1'b0;
    repeat (10) tick();
    en = 1'b1;
    wait_done(n);
    check("en_gap latency", 32'(n + 15), 32'd37);
    check("en_gap result", result, 32'h3FC0_0002);

    // done holds while en is low on the done cycle
    en = 1'b0;
    repeat (3) tick();
    check("done_hold", {31'd0, done}, 32'd1);
    en = 1'b1;
    tick();
    check("done_release", {31'd0, done}, 32'd0);

    // start coinciding with the done edge is taken on the following edge
    a = 32'hBFC0_0000; b = 32'h4000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (26) tick();
    start = 1'b1;
    tick();
    check("done_edge done", {30'd0, done, busy}, 32'd2);
    tick();
    start = 1'b0;
    check("done_edge accept", 32'(busy), 32'd1);
    wait_done(n);
    check("done_edge latency", 32'(n), 32'd27);
    check("done_edge result", result, 32'hC040_0000);
    tick();

    // Reset mid-operation aborts with no done
    a = 32'h3FC0_0000; b = 32'h4000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (11) tick();
    rst = 1'b0;
    tick();
    check("mid_rst outs", {30'd0, busy, done}, 32'd0);
    check("mid_rst result", result, 32'd0);
    rst = 1'b1;
    pulses = 0;
    repeat (40) begin tick(); if (done) pulses++; end
    check("mid_rst pulses", 32'(pulses), 32'd0);
    run_op("post_rst", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b000);

    // Randomized operands against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      if (i % 5 == 4) begin
        x = $urandom();
        y = $urandom();
      end else begin
        x = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 200)), 23'($urandom())};
        y = {1'($urandom_range(0, 1)), 8'($urandom_range(60, 200)), 23'($urandom())};
      end
      run_model($sformatf("rand%0d", i), x, y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
